// File: rtl/vga_framebuffer_reader.sv
// VGA scan-out for a double-buffered M10K frame buffer.
// Generates 640x480@60 timing, reads the front buffer in raster order, expands
// RGB 3-3-2 pixels to 8-bit channels and swaps buffers at the end of active video.
module vga_framebuffer_reader #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned PIX_W      = 8,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned ADDR_W     = 20
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_swap_req,
    output logic              o_swap_ack,
    output logic              o_front_buf,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [PIX_W-1:0]  i_rd_data,
    output logic [7:0]        o_vga_r,
    output logic [7:0]        o_vga_g,
    output logic [7:0]        o_vga_b,
    output logic              o_vga_hs,
    output logic              o_vga_vs,
    output logic              o_vga_blank_n
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    // Buffer 1 base; a constant, so no runtime multiply is needed.
    localparam logic [ADDR_W-1:0] FB_WORDS = ADDR_W'(H_ACTIVE * V_ACTIVE);

    logic [HW-1:0]         r_h_cnt;
    logic [VW-1:0]         r_v_cnt;
    logic [ADDR_W-1:0]     r_rd_addr;
    logic                  r_front_buf;
    logic                  r_swap_ack;
    logic [RD_LATENCY-1:0] r_act_pipe;
    logic [RD_LATENCY-1:0] r_hs_pipe;
    logic [RD_LATENCY-1:0] r_vs_pipe;
    logic [7:0]            r_vga_r;
    logic [7:0]            r_vga_g;
    logic [7:0]            r_vga_b;
    logic                  r_vga_hs;
    logic                  r_vga_vs;
    logic                  r_vga_blank_n;

    logic       w_h_last;
    logic       w_v_last;
    logic       w_v_last_active;
    logic       w_active;
    logic       w_hs_raw;
    logic       w_vs_raw;
    logic       w_swap_take;
    logic [7:0] w_exp_r;
    logic [7:0] w_exp_g;
    logic [7:0] w_exp_b;

    // Timing terms decoded from the raster counters.
    always_comb begin
        w_h_last        = (r_h_cnt == HW'(H_TOTAL - 1));
        w_v_last        = (r_v_cnt == VW'(V_TOTAL - 1));
        w_v_last_active = (r_v_cnt == VW'(V_ACTIVE - 1));
        w_active        = (r_h_cnt < HW'(H_ACTIVE)) && (r_v_cnt < VW'(V_ACTIVE));
        w_hs_raw        = !((r_h_cnt >= HW'(H_ACTIVE + H_FP)) &&
                            (r_h_cnt <  HW'(H_ACTIVE + H_FP + H_SYNC)));
        w_vs_raw        = !((r_v_cnt >= VW'(V_ACTIVE + V_FP)) &&
                            (r_v_cnt <  VW'(V_ACTIVE + V_FP + V_SYNC)));
        // Swap is only considered at the last clock of the last active line.
        w_swap_take     = w_h_last && w_v_last_active && i_swap_req;
    end

    // Horizontal / vertical raster counters.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_last ? '0 : r_v_cnt + VW'(1);
        end else begin
            r_h_cnt <= r_h_cnt + HW'(1);
        end
    end

    // Linear read address; reloads the frame base at the very last clock of a frame.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_addr <= '0;
        end else if (w_h_last && w_v_last) begin
            r_rd_addr <= r_front_buf ? FB_WORDS : '0;
        end else if (w_active) begin
            r_rd_addr <= r_rd_addr + ADDR_W'(1);
        end
    end

    // Front-buffer select and one-cycle swap acknowledge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_front_buf <= 1'b0;
            r_swap_ack  <= 1'b0;
        end else begin
            r_swap_ack <= w_swap_take;
            if (w_swap_take) begin
                r_front_buf <= ~r_front_buf;
            end
        end
    end

    // Delay line aligning active/sync terms with memory read data.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_act_pipe <= '0;
            r_hs_pipe  <= '1;
            r_vs_pipe  <= '1;
        end else begin
            r_act_pipe[0] <= w_active;
            r_hs_pipe[0]  <= w_hs_raw;
            r_vs_pipe[0]  <= w_vs_raw;
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                r_act_pipe[i] <= r_act_pipe[i-1];
                r_hs_pipe[i]  <= r_hs_pipe[i-1];
                r_vs_pipe[i]  <= r_vs_pipe[i-1];
            end
        end
    end

    // RGB 3-3-2 to 8-8-8 by bit replication.
    always_comb begin
        w_exp_r = {i_rd_data[7:5], i_rd_data[7:5], i_rd_data[7:6]};
        w_exp_g = {i_rd_data[4:2], i_rd_data[4:2], i_rd_data[4:3]};
        w_exp_b = {4{i_rd_data[1:0]}};
    end

    // Output register driving the VGA pins.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_vga_hs      <= 1'b1;
            r_vga_vs      <= 1'b1;
            r_vga_blank_n <= 1'b0;
            r_vga_r       <= '0;
            r_vga_g       <= '0;
            r_vga_b       <= '0;
        end else begin
            r_vga_hs      <= r_hs_pipe[RD_LATENCY-1];
            r_vga_vs      <= r_vs_pipe[RD_LATENCY-1];
            r_vga_blank_n <= r_act_pipe[RD_LATENCY-1];
            r_vga_r       <= r_act_pipe[RD_LATENCY-1] ? w_exp_r : 8'h00;
            r_vga_g       <= r_act_pipe[RD_LATENCY-1] ? w_exp_g : 8'h00;
            r_vga_b       <= r_act_pipe[RD_LATENCY-1] ? w_exp_b : 8'h00;
        end
    end

    assign o_rd_en       = w_active;
    assign o_rd_addr     = r_rd_addr;
    assign o_front_buf   = r_front_buf;
    assign o_swap_ack    = r_swap_ack;
    assign o_vga_r       = r_vga_r;
    assign o_vga_g       = r_vga_g;
    assign o_vga_b       = r_vga_b;
    assign o_vga_hs      = r_vga_hs;
    assign o_vga_vs      = r_vga_vs;
    assign o_vga_blank_n = r_vga_blank_n;

endmodule

// File: tb/tb_vga_framebuffer_reader.sv
// Bench for vga_framebuffer_reader on a shrunken raster (30x19 clocks per frame).
// A frame-level model predicts every output each cycle; literal checks pin the model.
module tb_vga_framebuffer_reader;

    localparam int HA = 16, HF = 4, HS = 6, HB = 4;
    localparam int VA = 12, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;  // 30
    localparam int VT = VA + VF + VS + VB;  // 19
    localparam int FT = HT * VT;            // 570
    localparam int FB = HA * VA;            // 192

    typedef struct packed {
        logic       blank_n;
        logic       hs;
        logic       vs;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pins_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        swap_req;
    logic        swap_ack;
    logic        front_buf;
    logic        rd_en;
    logic [19:0] rd_addr;
    logic [7:0]  rd_data;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vga_blank_n;

    vga_framebuffer_reader #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .PIX_W(8), .RD_LATENCY(2), .ADDR_W(20)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_swap_req(swap_req), .o_swap_ack(swap_ack),
        .o_front_buf(front_buf), .o_rd_en(rd_en), .o_rd_addr(rd_addr),
        .i_rd_data(rd_data), .o_vga_r(vga_r), .o_vga_g(vga_g), .o_vga_b(vga_b),
        .o_vga_hs(vga_hs), .o_vga_vs(vga_vs), .o_vga_blank_n(vga_blank_n)
    );

    always #5 clk = ~clk;

    // Frame-buffer contents as a pure function of address.
    function automatic logic [7:0] mem_f(input int unsigned a);
        logic [31:0] x;
        if (a == 0) return 8'hE0;
        if (a == 1) return 8'h03;
        x = a * 32'h9E3779B1;
        return x[15:8] ^ x[31:24];
    endfunction

    // Two-clock read latency memory.
    logic [7:0] mem_s1, mem_s2;
    always @(posedge clk) begin
        mem_s1 <= mem_f(rd_addr);
        mem_s2 <= mem_s1;
    end
    assign rd_data = mem_s2;

    int n_cmp = 0;
    int n_err = 0;

    // Model state
    int    m_t;
    bit    m_front, m_base, m_ack;
    pins_t pipe[$];
    int    g_cyc;
    bit    chk_en = 0;

    // Statistics gathered at each compare
    int ack_cnt, last_ack_cyc, hs_low, vs_low, first_hs_low, last_vs_fall, vs_period;
    logic prev_vs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, g_cyc);
        end
    endtask

    function automatic pins_t idle_pins();
        pins_t p;
        p.blank_n = 1'b0; p.hs = 1'b1; p.vs = 1'b1;
        p.r = 8'h00; p.g = 8'h00; p.b = 8'h00;
        return p;
    endfunction

    // Pixels already read this frame, plus the buffer base.
    function automatic int exp_addr(input int h, input int v, input bit base);
        int n;
        n = (v < VA) ? v * HA + ((h < HA) ? h : HA) : FB;
        return (base ? FB : 0) + n;
    endfunction

    function automatic pins_t exp_pins(input int h, input int v, input int addr);
        pins_t p;
        logic [7:0] d;
        p = idle_pins();
        p.blank_n = (h < HA) && (v < VA);
        p.hs = !((h >= HA + HF) && (h < HA + HF + HS));
        p.vs = !((v >= VA + VF) && (v < VA + VF + VS));
        if (p.blank_n) begin
            d = mem_f(addr);
            p.r = {d[7:5], d[7:5], d[7:6]};
            p.g = {d[4:2], d[4:2], d[4:3]};
            p.b = {d[1:0], d[1:0], d[1:0], d[1:0]};
        end
        return p;
    endfunction

    // Advance the model by one clock using the inputs the DUT will sample.
    task automatic model_step(input bit r, input bit s);
        int h, v;
        if (r) begin
            m_t = 0; m_front = 0; m_base = 0; m_ack = 0; g_cyc = 0;
            pipe = {idle_pins(), idle_pins(), idle_pins()};
            last_vs_fall = -1; first_hs_low = -1;
        end else begin
            h = m_t % HT;
            v = m_t / HT;
            pipe.push_back(exp_pins(h, v, exp_addr(h, v, m_base)));
            void'(pipe.pop_front());
            m_ack = (h == HT - 1) && (v == VA - 1) && s;
            if (m_ack) m_front = !m_front;
            if (m_t == FT - 1) begin
                m_base = m_front;
                m_t = 0;
            end else begin
                m_t++;
            end
            g_cyc++;
        end
    endtask

    // Compare process: every output, every cycle, against the model.
    always @(posedge clk) begin
        int h, v;
        #2;
        if (chk_en) begin
            h = m_t % HT;
            v = m_t / HT;
            chk("rd_en", 32'(rd_en), 32'((h < HA) && (v < VA)));
            chk("rd_addr", 32'(rd_addr), 32'(exp_addr(h, v, m_base)));
            chk("front_buf", 32'(front_buf), 32'(m_front));
            chk("swap_ack", 32'(swap_ack), 32'(m_ack));
            chk("blank_n", 32'(vga_blank_n), 32'(pipe[0].blank_n));
            chk("hs", 32'(vga_hs), 32'(pipe[0].hs));
            chk("vs", 32'(vga_vs), 32'(pipe[0].vs));
            chk("rgb", {8'h00, vga_r, vga_g, vga_b}, {8'h00, pipe[0].r, pipe[0].g, pipe[0].b});
            if (swap_ack === 1'b1) begin
                ack_cnt++;
                last_ack_cyc = g_cyc;
            end
            if (vga_hs === 1'b0) begin
                hs_low++;
                if (first_hs_low < 0) first_hs_low = g_cyc;
            end
            if (vga_vs === 1'b0) vs_low++;
            if (prev_vs === 1'b1 && vga_vs === 1'b0) begin
                if (last_vs_fall >= 0) vs_period = g_cyc - last_vs_fall;
                last_vs_fall = g_cyc;
            end
            prev_vs = vga_vs;
        end
    end

    task automatic tick(input bit r, input bit s);
        rst = r;
        swap_req = s;
        model_step(r, s);
        chk_en = 1;
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit s);
        for (int i = 0; i < n; i++) tick(1'b0, s);
    endtask

    // Hold swap_req until an ack is seen, bounded by two frames.
    task automatic swap_until_ack();
        for (int i = 0; i < 2 * FT; i++) begin
            tick(1'b0, 1'b1);
            if (swap_ack === 1'b1) break;
        end
    endtask

    initial begin
        bit s;
        int ack_before;
        rst = 1'b1;
        swap_req = 1'b0;
        ack_cnt = 0; last_ack_cyc = -1; hs_low = 0; vs_low = 0;
        vs_period = -1; prev_vs = 1'b1; first_hs_low = -1; last_vs_fall = -1;
        @(negedge clk);

        // Reset and first line
        tick(1, 0); tick(1, 0); tick(1, 0);
        chk("lit_reset_rd_en", 32'(rd_en), 32'd1);
        chk("lit_reset_addr", 32'(rd_addr), 32'd0);
        chk("lit_reset_pins", {29'd0, vga_hs, vga_vs, vga_blank_n}, 32'b110);
        run(3, 0);
        chk("lit_pix0", {7'd0, vga_blank_n, vga_r, vga_g, vga_b}, 32'h01FF0000);
        run(1, 0);
        chk("lit_pix1", {8'd0, vga_r, vga_g, vga_b}, 32'h000000FF);
        run(11, 0);
        chk("lit_addr_h15", 32'(rd_addr), 32'd15);
        run(1, 0);
        chk("lit_rd_en_h16", 32'(rd_en), 32'd0);
        run(14, 0);
        chk("lit_line1_addr", 32'(rd_addr), 32'd16);

        // Two frames of sync timing
        hs_low = 0; vs_low = 0;
        run(2 * FT, 0);
        chk("lit_first_hs_low", 32'(first_hs_low), 32'd23);
        chk("lit_hs_low_cnt", 32'(hs_low), 32'(2 * VT * HS));
        chk("lit_vs_low_cnt", 32'(vs_low), 32'(2 * VS * HT));
        chk("lit_frame_period", 32'(vs_period), 32'd570);

        // Swap request early in frame 0, then a second swap back
        tick(1, 0);
        ack_cnt = 0;
        run(10, 0);
        swap_until_ack();
        chk("lit_ack1_cyc", 32'(last_ack_cyc), 32'd360);
        chk("lit_front1", 32'(front_buf), 32'd1);
        run(FT - g_cyc, 0);
        chk("lit_frame1_base", 32'(rd_addr), 32'd192);
        run(10, 0);
        swap_until_ack();
        chk("lit_ack2_cyc", 32'(last_ack_cyc), 32'd930);
        run(2 * FT - g_cyc, 0);
        chk("lit_frame2_base", 32'(rd_addr), 32'd0);
        chk("lit_front2", 32'(front_buf), 32'd0);

        // Request only during vertical blanking: ignored
        ack_before = ack_cnt;
        run((VA + 1) * HT, 0);
        run((VT - VA - 1) * HT, 1);
        run(FT, 0);
        chk("lit_blank_req_ack", 32'(ack_cnt), 32'(ack_before));
        chk("lit_blank_req_front", 32'(front_buf), 32'd0);

        // Mid-frame reset with front_buf=1
        swap_until_ack();
        run((FT - g_cyc % FT) + 5 * HT + 7, 0);
        chk("lit_pre_reset_front", 32'(front_buf), 32'd1);
        chk("lit_pre_reset_addr", 32'(rd_addr), 32'(FB + 5 * HA + 7));
        tick(1, 0);
        chk("lit_post_reset", {30'd0, front_buf, vga_blank_n}, 32'd0);
        chk("lit_post_reset_addr", 32'(rd_addr), 32'd0);
        run(2, 0);
        chk("lit_post_reset_c2", {7'd0, vga_blank_n, vga_r, vga_g, vga_b}, 32'd0);
        run(1, 0);
        chk("lit_post_reset_c3", {7'd0, vga_blank_n, vga_r, vga_g, vga_b}, 32'h01FF0000);

        // Random swap requests with an occasional reset
        s = 0;
        for (int i = 0; i < 8 * FT; i++) begin
            if ($urandom_range(0, 99) < 2) s = !s;
            tick(($urandom_range(0, 2999) == 0), s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
